// File: rtl/shift_reg_word.sv
// Serial-to-parallel word assembler with a valid/ready serial input, a one-entry
// holding register on the parallel side, and a D flip-flop style copy of the last bit.
module shift_reg_word #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     D,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     Q,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic [WIDTH-1:0]         par_out,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    STALLED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             ov_q, ov_d;
  logic             q_q, q_d;

  logic [WIDTH-1:0] shifted_s;
  logic             acc_s;
  logic             last_s;
  logic             hold_free_s;
  logic             consume_s;

  // in_ready comes only from the registered state, never from out_ready/in_valid
  assign in_ready    = (state_q == COLLECT);
  assign acc_s       = in_valid && in_ready;
  assign last_s      = (cnt_q == CNT_LAST);
  assign hold_free_s = !ov_q || out_ready;
  assign consume_s   = ov_q && out_ready;

  assign Q         = q_q;
  assign bit_cnt   = cnt_q;
  assign par_out   = par_q;
  assign out_valid = ov_q;

  always_comb begin
    shifted_s = sreg_q;
    if (MSB_FIRST != 0) begin
      shifted_s = {sreg_q[WIDTH-2:0], D};
    end else begin
      shifted_s = {D, sreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    ov_d    = ov_q;
    q_d     = q_q;
    case (state_q)
      COLLECT: begin
        if (acc_s) begin
          sreg_d = shifted_s;
          q_d    = D;
          if (last_s) begin
            cnt_d = '0;
            // A completed word overwrites the holding register whenever it is
            // free, which also covers a same-cycle consume without a bubble.
            if (hold_free_s) begin
              par_d = shifted_s;
              ov_d  = 1'b1;
            end else begin
              state_d = STALLED;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (consume_s) begin
              ov_d = 1'b0;
            end else begin
              ov_d = ov_q;
            end
          end
        end else begin
          if (consume_s) begin
            ov_d = 1'b0;
          end else begin
            ov_d = ov_q;
          end
        end
      end
      STALLED: begin
        // out_valid is necessarily set here; releasing moves sreg into holding
        if (out_ready) begin
          par_d   = sreg_q;
          ov_d    = 1'b1;
          state_d = COLLECT;
        end else begin
          state_d = STALLED;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= COLLECT;
      sreg_q  <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      ov_q    <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ov_q    <= ov_d;
      q_q     <= q_d;
    end
  end

endmodule

// File: tb/tb_shift_reg_word.sv
// Randomized bench for shift_reg_word: MSB-first and LSB-first instances share
// stimulus and are compared against a bit-list/word-queue reference model.
module tb_shift_reg_word;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d = 1'b0;
  logic       iv = 1'b0;
  logic       ordy = 1'b0;

  logic       ir_m, q_m, ov_m, ir_l, q_l, ov_l;
  logic [2:0] cnt_m, cnt_l;
  logic [7:0] par_m, par_l;

  int chk = 0;
  int pass = 0;

  // reference model state
  logic       m_bits [8];
  int         m_cnt;
  logic       m_q;
  logic       m_hv;
  logic [7:0] m_hw_m, m_hw_l;
  logic       m_pv;
  logic [7:0] m_pw_m, m_pw_l;

  always #5 clk = ~clk;

  shift_reg_word #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .sys_clk(clk), .sys_rst(rst), .D(d), .in_valid(iv), .in_ready(ir_m),
    .Q(q_m), .bit_cnt(cnt_m), .par_out(par_m), .out_valid(ov_m), .out_ready(ordy)
  );

  shift_reg_word #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .sys_clk(clk), .sys_rst(rst), .D(d), .in_valid(iv), .in_ready(ir_l),
    .Q(q_l), .bit_cnt(cnt_l), .par_out(par_l), .out_valid(ov_l), .out_ready(ordy)
  );

  function automatic logic [27:0] obs_vec();
    return {ir_m, ov_m, q_m, cnt_m, par_m, ir_l, ov_l, q_l, cnt_l, par_l};
  endfunction

  function automatic logic [27:0] exp_vec();
    logic [2:0] c;
    c = 3'(m_cnt);
    return {!m_pv, m_hv, m_q, c, m_hw_m, !m_pv, m_hv, m_q, c, m_hw_l};
  endfunction

  // Advance the model by one rising edge using the inputs the DUT sampled.
  task automatic model_step();
    logic [7:0] wm, wl;
    if (rst) begin
      m_cnt = 0; m_q = 1'b0; m_hv = 1'b0; m_hw_m = 8'h00; m_hw_l = 8'h00;
      m_pv = 1'b0; m_pw_m = 8'h00; m_pw_l = 8'h00;
      for (int i = 0; i < 8; i++) m_bits[i] = 1'b0;
    end else if (m_pv) begin
      if (ordy) begin
        m_hw_m = m_pw_m; m_hw_l = m_pw_l; m_pv = 1'b0; m_hv = 1'b1;
      end
    end else begin
      if (iv) begin
        m_q = d;
        m_bits[m_cnt] = d;
        m_cnt = m_cnt + 1;
        if (m_cnt == 8) begin
          m_cnt = 0;
          for (int i = 0; i < 8; i++) begin
            wm[7-i] = m_bits[i];
            wl[i]   = m_bits[i];
          end
          if (!m_hv || ordy) begin
            m_hw_m = wm; m_hw_l = wl; m_hv = 1'b1;
          end else begin
            m_pw_m = wm; m_pw_l = wl; m_pv = 1'b1;
          end
        end else if (m_hv && ordy) begin
          m_hv = 1'b0;
        end
      end else if (m_hv && ordy) begin
        m_hv = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic b, input logic o);
    rst = r; iv = v; d = b; ordy = o;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] w;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk++;
    if ({ov_m, cnt_m, q_m, par_m, ir_m} !== {1'b0, 3'd0, 1'b0, 8'h00, 1'b1}) begin
      $display("FAIL reset_state: got ov=%b cnt=%0d q=%b par=%h ir=%b expected 0/0/0/00/1",
               ov_m, cnt_m, q_m, par_m, ir_m);
    end else pass++;
    w = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, w[7-i], 1'b1);
      chk++;
      if (ov_m !== (i == 7)) begin
        $display("FAIL reset_first_word bit%0d: out_valid got %b expected %b", i, ov_m, (i == 7));
      end else pass++;
    end
    chk++;
    if (par_m !== w) begin
      $display("FAIL reset_first_word_data: got %h expected %h", par_m, w);
    end else pass++;
  endtask

  task automatic test_packing();
    logic [7:0] s;
    s = 8'b1011_0010;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, s[7-i], 1'b1);
      chk++;
      if (q_m !== s[7-i] || q_l !== s[7-i]) begin
        $display("FAIL pack_q bit%0d: got %b/%b expected %b", i, q_m, q_l, s[7-i]);
      end else pass++;
    end
    chk++;
    if ({ov_m, par_m, ov_l, par_l} !== {1'b1, 8'hB2, 1'b1, 8'h4D}) begin
      $display("FAIL pack_word: got msb=%h lsb=%h ov=%b%b expected B2 4D 11",
               par_m, par_l, ov_m, ov_l);
    end else pass++;
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk++;
    if (ov_m !== 1'b0 || par_m !== 8'hB2) begin
      $display("FAIL pack_pulse: got ov=%b par=%h expected 0 B2", ov_m, par_m);
    end else pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] s;
    s = 16'hA53C;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk++;
      if (ir_m !== 1'b1) begin
        $display("FAIL bp_ready_early bit%0d: got %b expected 1", i, ir_m);
      end else pass++;
      cycle(1'b0, 1'b1, s[15-i], 1'b0);
    end
    chk++;
    if ({ir_m, ov_m, par_m} !== {1'b0, 1'b1, 8'hA5}) begin
      $display("FAIL bp_stalled: got ir=%b ov=%b par=%h expected 0 1 A5", ir_m, ov_m, par_m);
    end else pass++;
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk++;
    if (obs_vec() !== exp_vec()) begin
      $display("FAIL bp_hold: got %h expected %h", obs_vec(), exp_vec());
    end else pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk++;
    if ({ir_m, ov_m, par_m} !== {1'b1, 1'b1, 8'h3C}) begin
      $display("FAIL bp_release: got ir=%b ov=%b par=%h expected 1 1 3C", ir_m, ov_m, par_m);
    end else pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk++;
    if (ov_m !== 1'b0 || obs_vec() !== exp_vec()) begin
      $display("FAIL bp_drain: got %h expected %h", obs_vec(), exp_vec());
    end else pass++;
  endtask

  task automatic test_gapped();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, (i % 2 == 0), 1'($urandom), 1'b1);
      chk++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL gapped cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end else pass++;
      chk++;
      if (cnt_m !== 3'((i / 2 + 1) % 8)) begin
        $display("FAIL gapped_cnt cyc%0d: got %0d expected %0d", i, cnt_m, (i / 2 + 1) % 8);
      end else pass++;
    end
  endtask

  task automatic test_midword_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'($urandom), 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk++;
    if (cnt_m !== 3'd0 || ov_m !== 1'b0) begin
      $display("FAIL mid_reset_clear: got cnt=%0d ov=%b expected 0 0", cnt_m, ov_m);
    end else pass++;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
    chk++;
    if ({par_m, par_l, cnt_m, ov_m} !== {8'hFF, 8'hFF, 3'd0, 1'b1}) begin
      $display("FAIL mid_reset_word: got %h/%h cnt=%0d ov=%b expected FF/FF 0 1",
               par_m, par_l, cnt_m, ov_m);
    end else pass++;
  endtask

  task automatic test_random();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
            ($urandom_range(2) == 0));
      chk++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL random cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_backpressure();
    test_gapped();
    test_midword_reset();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
